// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - clock-FSM state encodings, scan FSM and digit/mask constants
package display_pkg;

  localparam logic [2:0] IDLE_S  = 3'b000;
  localparam logic [2:0] SET_HR  = 3'b001;
  localparam logic [2:0] SET_MIN = 3'b010;
  localparam logic [2:0] ALM_HR  = 3'b100;
  localparam logic [2:0] ALM_MIN = 3'b101;

  typedef enum logic [1:0] {
    SC_IDLE  = 2'd0,
    SC_SCAN  = 2'd1,
    SC_BLANK = 2'd2
  } scan_state_e;

  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } blink_phase_e;

  localparam logic [1:0] DIG_MIN_U = 2'd0;
  localparam logic [1:0] DIG_MIN_T = 2'd1;
  localparam logic [1:0] DIG_HR_U  = 2'd2;
  localparam logic [1:0] DIG_HR_T  = 2'd3;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_HR   = 4'b1100;
  localparam logic [3:0] MASK_MIN  = 4'b0011;

  function automatic logic [3:0] edit_mask_of(input logic [2:0] st);
    case (st)
      SET_HR, ALM_HR:   return MASK_HR;
      SET_MIN, ALM_MIN: return MASK_MIN;
      default:          return MASK_NONE;
    endcase
  endfunction

  function automatic logic is_alarm_state(input logic [2:0] st);
    return (st == ALM_HR) || (st == ALM_MIN);
  endfunction

endpackage

// File: rtl/blink_gen.sv
// rtl/blink_gen.sv - frame counter and blink phase, advanced once per frame boundary
module blink_gen
  import display_pkg::*;
#(
  parameter int BLINK_FRAMES = 125
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         advance_i,
  output blink_phase_e phase_next_o
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  blink_phase_e  phase_q, phase_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (advance_i) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_d     = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q <= '0;
      phase_q     <= PH_ON;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Exposed pre-register so the new phase applies from the first cycle of the new frame.
  assign phase_next_o = phase_d;

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 4-digit scan sequencer with blanking gap, source select and edit blink
module display_scan_controller
  import display_pkg::*;
#(
  parameter int DIGIT_TICKS  = 100000,
  parameter int BLANK_TICKS  = 2000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] state,
  output logic [1:0] sel,
  output logic       digit_on,
  output logic       src_alarm,
  output logic       frame_tick
);

  localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(DIGIT_TICKS - BLANK_TICKS - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_TICKS - 1);

  scan_state_e   fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    mask_q, mask_d;
  logic          src_q, src_d;
  logic          on_q, on_d;
  logic          tick_q, tick_d;
  blink_phase_e  phase_next;

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    mask_d = mask_q;
    src_d  = src_q;
    tick_d = 1'b0;
    if (!en) begin
      fsm_d = SC_IDLE;
      cnt_d = '0;
      sel_d = DIG_MIN_U;
    end else begin
      case (fsm_q)
        SC_IDLE: begin
          fsm_d  = SC_SCAN;
          cnt_d  = '0;
          sel_d  = DIG_MIN_U;
          mask_d = edit_mask_of(state);
          src_d  = is_alarm_state(state);
        end
        SC_SCAN: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SCAN_LAST) fsm_d = SC_BLANK;
        end
        SC_BLANK: begin
          if (cnt_q == SLOT_LAST) begin
            fsm_d = SC_SCAN;
            cnt_d = '0;
            sel_d = sel_q + 2'd1;
            // Frame boundary: the only point where source and edit mask may change.
            if (sel_q == DIG_HR_T) begin
              tick_d = 1'b1;
              mask_d = edit_mask_of(state);
              src_d  = is_alarm_state(state);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          fsm_d = SC_IDLE;
          cnt_d = '0;
          sel_d = DIG_MIN_U;
        end
      endcase
    end
  end

  assign on_d = (fsm_d == SC_SCAN) && !((phase_next == PH_OFF) && mask_d[sel_d]);

  blink_gen #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_gen (
    .clk_i       (clk),
    .rst_ni      (rst),
    .advance_i   (tick_d),
    .phase_next_o(phase_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q  <= SC_IDLE;
      cnt_q  <= '0;
      sel_q  <= DIG_MIN_U;
      mask_q <= MASK_NONE;
      src_q  <= 1'b0;
      on_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      mask_q <= mask_d;
      src_q  <= src_d;
      on_q   <= on_d;
      tick_q <= tick_d;
    end
  end

  assign sel        = sel_q;
  assign digit_on   = on_q;
  assign src_alarm  = src_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed vector table plus randomized run against a frame-level model
module tb_display_scan_controller;

  localparam int DT    = 8;
  localparam int BT    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic [2:0] state = 3'd0;
  logic [1:0] sel;
  logic       digit_on, src_alarm, frame_tick;

  int tests = 0;
  int fails = 0;

  display_scan_controller #(
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .state     (state),
    .sel       (sel),
    .digit_on  (digit_on),
    .src_alarm (src_alarm),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Model: position in the scan measured in cycles since scanning began.
  bit         m_run = 1'b0;
  int         m_t = 0;
  int         m_wraps = 0;
  logic [2:0] m_lat = 3'd0;

  task automatic model_reset();
    m_run = 1'b0; m_t = 0; m_wraps = 0; m_lat = 3'd0;
  endtask

  task automatic model_edge();
    if (!rst) model_reset();
    else if (!en) m_run = 1'b0;
    else if (!m_run) begin
      m_run = 1'b1; m_t = 0; m_lat = state;
    end else begin
      m_t++;
      if (m_t % FRAME == 0) begin
        m_wraps++;
        m_lat = state;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int  slot;
    bit  edited, blink_off, exp_on;
    slot      = (m_t / DT) % 4;
    edited    = (slot >= 2) ? (m_lat == 3'b001 || m_lat == 3'b100)
                            : (m_lat == 3'b010 || m_lat == 3'b101);
    blink_off = ((m_wraps / BF) % 2) == 1;
    exp_on    = m_run && ((m_t % DT) < DT - BT) && !(blink_off && edited);
    check("model_sel", 32'(sel), m_run ? 32'(slot) : 32'd0);
    check("model_digit_on", 32'(digit_on), 32'(exp_on));
    check("model_frame_tick", 32'(frame_tick), 32'(m_run && m_t > 0 && (m_t % FRAME) == 0));
    check("model_src_alarm", 32'(src_alarm), 32'(m_lat == 3'b100 || m_lat == 3'b101));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    int         n;
    logic       en;
    logic [2:0] st;
    logic [1:0] sel;
    logic       on;
    logic       tick;
    logic       src;
  } vec_t;
  vec_t vq[$];

  task automatic add(input int n, input logic e, input logic [2:0] s, input logic [1:0] xs,
                     input logic xo, input logic xt, input logic xa);
    vec_t v;
    v.n = n; v.en = e; v.st = s; v.sel = xs; v.on = xo; v.tick = xt; v.src = xa;
    vq.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with en=1: outputs stay quiet
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_sel", 32'(sel), 0);
      check("rst_digit_on", 32'(digit_on), 0);
      check("rst_frame_tick", 32'(frame_tick), 0);
      check("rst_src_alarm", 32'(src_alarm), 0);
    end
    rst = 1'b1;

    // n, en, state, sel, digit_on, frame_tick, src_alarm
    add(1, 1, 3'd0, 0, 1, 0, 0);   add(5, 1, 3'd0, 0, 1, 0, 0);
    add(1, 1, 3'd0, 0, 0, 0, 0);   add(1, 1, 3'd0, 0, 0, 0, 0);
    add(1, 1, 3'd0, 1, 1, 0, 0);   add(16, 1, 3'd0, 3, 1, 0, 0);
    add(8, 1, 3'd0, 0, 1, 1, 0);   add(1, 1, 3'd0, 0, 1, 0, 0);
    add(6, 1, 3'd5, 0, 0, 0, 0);   add(25, 1, 3'd5, 0, 0, 1, 1);
    add(8, 1, 3'd5, 1, 0, 0, 1);   add(8, 1, 3'd5, 2, 1, 0, 1);
    add(8, 1, 3'd5, 3, 1, 0, 1);   add(8, 1, 3'd5, 0, 0, 1, 1);
    add(32, 1, 3'd5, 0, 1, 1, 1);  add(32, 1, 3'd1, 0, 1, 1, 0);
    add(32, 1, 3'd1, 0, 1, 1, 0);  add(16, 1, 3'd1, 2, 0, 0, 0);
    add(8, 1, 3'd1, 3, 0, 0, 0);   add(8, 1, 3'd0, 0, 1, 1, 0);
    add(16, 1, 3'd0, 2, 1, 0, 0);  add(1, 1, 3'd0, 2, 1, 0, 0);
    add(1, 0, 3'd0, 0, 0, 0, 0);   add(3, 0, 3'd0, 0, 0, 0, 0);
    add(1, 1, 3'd0, 0, 1, 0, 0);   add(5, 1, 3'd0, 0, 1, 0, 0);
    add(1, 1, 3'd0, 0, 0, 0, 0);

    foreach (vq[k]) begin
      en = vq[k].en;
      state = vq[k].st;
      for (int c = 0; c < vq[k].n; c++) step();
      check($sformatf("vec%0d_sel", k), 32'(sel), 32'(vq[k].sel));
      check($sformatf("vec%0d_digit_on", k), 32'(digit_on), 32'(vq[k].on));
      check($sformatf("vec%0d_frame_tick", k), 32'(frame_tick), 32'(vq[k].tick));
      check($sformatf("vec%0d_src_alarm", k), 32'(src_alarm), 32'(vq[k].src));
    end

    // Randomized run: enable gaps and mid-frame state changes
    for (int i = 0; i < 4000; i++) begin
      if (en) begin
        if ($urandom_range(0, 99) < 2) en = 1'b0;
      end else if ($urandom_range(0, 99) < 20) en = 1'b1;
      if ($urandom_range(0, 39) == 0) state = 3'($urandom_range(0, 7));
      step();
      check_model();
    end

    // Async reset in the middle of a SCAN slot
    en = 1'b1;
    state = 3'b001;
    for (int i = 0; i < 12; i++) step();
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("async_sel", 32'(sel), 0);
    check("async_digit_on", 32'(digit_on), 0);
    check("async_frame_tick", 32'(frame_tick), 0);
    check("async_src_alarm", 32'(src_alarm), 0);
    step();
    check_model();
    rst = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
